dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_ram.sv | 37 +++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM state encodings,
// reset/write enable levels and the access fault check.
// Latency: n/a (declarations only). Backpressure: n/a.
`timescale 1ns/1ps
package dmem_responder_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Pipeline-wide level constants.
   localparam logic        RstEnable   = 1'b0;   // resetn level that resets
   localparam logic        WriteEnable = 1'b1;   // we level that writes
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;

   // A request faults when it is not word aligned or its word index falls
   // outside the memory.
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input int unsigned depth_words);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with byte-lane write enables.
// Latency: 1 clock for reads; rdata only changes on an enabled read.
// Backpressure: none; one access per enabled cycle.
// Ports: clk, en (access strobe), we (1=write), sel (byte lanes),
//        addr (word index), wdata (store data), rdata (registered read data).
`timescale 1ns/1ps
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    sel,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   // Contents are deliberately not reset.
   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (sel[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: wait states, fault check, RAM access.
// Latency: WAIT_CYCLES+1 clocks to ack_o for in-range accesses, 1 clock for faults.
// Backpressure: stall_o = req_i & ~ack_o holds the MEM stage; dropping req_i in WAIT aborts.
// Ports: clk, resetn (sync, active-low); req_i/we_i/addr_i/wdata_i/sel_i request;
//        rdata_o/ack_o/err_o response; stall_o pipeline hold.
`timescale 1ns/1ps
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;

   // Holding registers for the accepted request. Only the word index of the
   // address is kept; alignment and range are resolved into fault_q.
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [31:0]   wdata_q;
   logic [3:0]    sel_q;
   logic          fault_q;

   // rdata_o is 0 after reset or a fault, otherwise the RAM's last read word.
   logic          zero_q;

   logic          req_fault;
   logic          capture;
   logic          enter_resp;
   logic [AW-1:0] acc_addr;
   logic          acc_we;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_sel;
   logic          acc_fault;
   logic          ram_en;
   logic [31:0]   ram_rdata;

   assign req_fault  = addr_fault(addr_i, DEPTH_WORDS);
   assign capture    = (state_q == IDLE) && req_i;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // With no wait states RESP is entered on the capture edge itself, so the
   // RAM sees the fields being captured; from WAIT it sees the held fields.
   always_comb begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_wdata = wdata_q;
      acc_sel   = sel_q;
      acc_fault = fault_q;
      if (state_q == IDLE) begin
         acc_addr  = addr_i[AW+1:2];
         acc_we    = we_i;
         acc_wdata = wdata_i;
         acc_sel   = sel_i;
         acc_fault = req_fault;
      end
   end

   // A reset on the same edge must not commit a write.
   assign ram_en = enter_resp && !acc_fault && (resetn != RstEnable);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (req_fault || (WAIT_CYCLES == 0)) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (!req_i) begin
               // Pipeline flush: drop the access silently.
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetn == RstEnable) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= ZeroWord;
         sel_q   <= 4'd0;
         fault_q <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            addr_q  <= addr_i[AW+1:2];
            we_q    <= we_i;
            wdata_q <= wdata_i;
            sel_q   <= sel_i;
            fault_q <= req_fault;
         end
         if (enter_resp) begin
            if (acc_fault) begin
               zero_q <= 1'b1;
            end else if (acc_we != WriteEnable) begin
               zero_q <= 1'b0;
            end
         end
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (acc_we == WriteEnable),
      .sel   (acc_sel),
      .addr  (acc_addr),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign ack_o   = (state_q == RESP);
   assign err_o   = ack_o && fault_q;
   assign rdata_o = zero_q ? ZeroWord : ram_rdata;
   assign stall_o = (resetn != RstEnable) && req_i && !ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        t_req = 1'b0;
   logic        t_we = 1'b0;
   logic [31:0] t_addr = 32'h0;
   logic [31:0] t_wdata = 32'h0;
   logic [3:0]  t_sel = 4'h0;
   logic        use_b = 1'b0;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance

   logic        req_a, req_b;
   logic [31:0] rdata_a, rdata_b, rdata;
   logic        ack_a, ack_b, ack;
   logic        err_a, err_b, err;
   logic        stall_a, stall_b, stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign req_a = t_req && !use_b;
   assign req_b = t_req && use_b;
   assign rdata = use_b ? rdata_b : rdata_a;
   assign ack   = use_b ? ack_b   : ack_a;
   assign err   = use_b ? err_b   : err_a;
   assign stall = use_b ? stall_b : stall_a;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .resetn(resetn), .req_i(req_a), .we_i(t_we), .addr_i(t_addr),
      .wdata_i(t_wdata), .sel_i(t_sel), .rdata_o(rdata_a), .ack_o(ack_a),
      .err_o(err_a), .stall_o(stall_a)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .resetn(resetn), .req_i(req_b), .we_i(t_we), .addr_i(t_addr),
      .wdata_i(t_wdata), .sel_i(t_sel), .rdata_o(rdata_b), .ack_o(ack_b),
      .err_o(err_b), .stall_o(stall_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access. Called 1ns after a rising edge; returns 1ns after
   // the edge that follows the ack cycle. With mutate set, the request fields
   // are scrambled while the access waits.
   task automatic access(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_rd, input logic mutate);
      int   n;
      logic stall_ok;
      t_req = 1'b1; t_we = we; t_addr = addr; t_wdata = wdata; t_sel = sel;
      #1;
      stall_ok = stall;
      n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (ack) break;
         if (!stall) stall_ok = 1'b0;
         if (mutate) begin
            t_addr = 32'h10; t_wdata = 32'hFFFF_FFFF; t_sel = 4'hF;
         end
      end
      chk({tag, " stall"}, 32'(stall_ok), 32'd1);
      chk({tag, " ack"},   32'(ack),      32'd1);
      chk({tag, " lat"},   32'(n),        32'(exp_lat));
      chk({tag, " err"},   32'(err),      32'(exp_err));
      chk({tag, " rdata"}, rdata,         exp_rd);
      chk({tag, " stall@ack"}, 32'(stall), 32'd0);
      t_req = 1'b0;
      tick();
      chk({tag, " ack pulse"}, 32'(ack), 32'd0);
      chk({tag, " err idle"},  32'(err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;

      // Reset with a request pending: outputs must all be low.
      resetn = 1'b0;
      t_req  = 1'b1;
      tick(); tick();
      chk("rst ack",   32'(ack),   32'd0);
      chk("rst err",   32'(err),   32'd0);
      chk("rst rdata", rdata,      32'h0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst rdata b", rdata_b,  32'h0);
      t_req  = 1'b0;
      resetn = 1'b1;
      tick();

      // Basic write then read.
      access("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0, 1'b0);
      access("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      chk("rd10 hold", rdata, 32'hDEAD_BEEF);

      // Byte lanes; write responses leave rdata alone.
      access("wr20",  1'b1, 32'h20, 32'h1122_3344, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      access("wr20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      access("rd20",  1'b0, 32'h20, 32'h0, 4'h0, 3, 1'b0, 32'h11BB_33DD, 1'b0);

      // Faults: misaligned, out of range, and a misaligned write.
      access("flt13",   1'b0, 32'h13,   32'h0, 4'h0, 1, 1'b1, 32'h0, 1'b0);
      access("flt1000", 1'b0, 32'h1000, 32'h0, 4'h0, 1, 1'b1, 32'h0, 1'b0);
      access("fltwr11", 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0, 1'b0);
      access("rd10 post flt", 1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
      access("rd20 post flt", 1'b0, 32'h20, 32'h0, 4'h0, 3, 1'b0, 32'h11BB_33DD, 1'b0);

      // Flush: write of 0x55 dropped during WAIT.
      access("wr40", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h11BB_33DD, 1'b0);
      t_req = 1'b1; t_we = 1'b1; t_addr = 32'h40; t_wdata = 32'h55; t_sel = 4'hF;
      tick();
      chk("flush stall", 32'(stall), 32'd1);
      t_req = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ack) acks++;
      end
      chk("flush no ack", 32'(acks), 32'd0);
      chk("flush rdata", rdata, 32'h11BB_33DD);
      access("rd40 post flush", 1'b0, 32'h40, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 1'b0);

      // Inputs changing during WAIT are ignored.
      access("wr40 mut", 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b1);
      access("rd40 mut", 1'b0, 32'h40, 32'h0, 4'h0, 3, 1'b0, 32'hA5A5_A5A5, 1'b0);
      access("rd10 mut", 1'b0, 32'h10, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);

      // Reset while a write waits.
      t_req = 1'b1; t_we = 1'b1; t_addr = 32'h40; t_wdata = 32'h9999_9999; t_sel = 4'hF;
      tick();
      resetn = 1'b0;
      tick();
      chk("midrst ack",   32'(ack),   32'd0);
      chk("midrst err",   32'(err),   32'd0);
      chk("midrst rdata", rdata,      32'h0);
      chk("midrst stall", 32'(stall), 32'd0);
      resetn = 1'b1;
      t_req  = 1'b0;
      tick();
      access("rd40 post rst", 1'b0, 32'h40, 32'h0, 4'h0, 3, 1'b0, 32'hA5A5_A5A5, 1'b0);

      // Zero-wait instance: back-to-back reads with req_i held high.
      use_b = 1'b1;
      #1;
      access("b wr08", 1'b1, 32'h08, 32'hCAFE_0001, 4'hF, 1, 1'b0, 32'h0, 1'b0);
      access("b wr0c", 1'b1, 32'h0C, 32'hCAFE_0002, 4'hF, 1, 1'b0, 32'h0, 1'b0);
      t_req = 1'b1; t_we = 1'b0; t_addr = 32'h08;
      tick();
      chk("b2b ack1",   32'(ack), 32'd1);
      chk("b2b rdata1", rdata,    32'hCAFE_0001);
      t_addr = 32'h0C;
      tick();
      chk("b2b gap ack",   32'(ack),   32'd0);
      chk("b2b gap stall", 32'(stall), 32'd1);
      tick();
      chk("b2b ack2",   32'(ack), 32'd1);
      chk("b2b rdata2", rdata,    32'hCAFE_0002);
      t_req = 1'b0;
      tick();
      chk("b2b end ack",  32'(ack), 32'd0);
      chk("b2b hold",     rdata,    32'hCAFE_0002);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
